// File: rtl/strawman_pkg.sv
// Shared definitions for the strawman link TX/RX blocks: command codes,
// header layout, legal length range, FSM states and request payload.
package strawman_pkg;

    localparam int unsigned FLIT_W = 40;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned FEAT_W = 6;
    localparam int unsigned CNT_W  = 6;

    localparam logic [CMD_W-1:0] CMD_READ_REQ  = 3'b000;
    localparam logic [CMD_W-1:0] CMD_WRITE_REQ = 3'b001;
    localparam logic [CMD_W-1:0] CMD_READ_RESP = 3'b010;

    // Length field is log2 of the word count; 5 (32 words) is the largest legal size.
    localparam logic [LEN_W-1:0] LEN_MAX_LEGAL = 3'd5;

    localparam int unsigned HDR_EXT_BIT     = 0;
    localparam int unsigned HDR_ONE_BIT     = 1;
    localparam int unsigned HDR_CMD_LSB     = 2;
    localparam int unsigned HDR_LEN_LSB     = 5;
    localparam int unsigned HDR_PAYLOAD_LSB = 8;
    localparam int unsigned HDR_F1_LSB      = 8;
    localparam int unsigned HDR_F2_LSB      = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_EX_ADDR = 2'd2,
        ST_BODY    = 2'd3
    } state_e;

    typedef struct packed {
        logic              ext;
        logic [CMD_W-1:0]  cmd;
        logic [LEN_W-1:0]  length;
        logic [FEAT_W-1:0] feature1;
        logic [FEAT_W-1:0] feature2;
    } req_ctl_t;

    function automatic logic is_legal(input logic [CMD_W-1:0] cmd, input logic [LEN_W-1:0] length);
        return (cmd <= CMD_READ_RESP) && (length <= LEN_MAX_LEGAL);
    endfunction

    function automatic logic [CNT_W-1:0] word_count(input logic [LEN_W-1:0] length);
        return CNT_W'(1) << length;
    endfunction

endpackage

// File: rtl/strawman_tx_fsm_if.sv
// Request, payload and flit-output bundle between a packet source and the TX FSM.
interface strawman_tx_fsm_if import strawman_pkg::*; #(
    parameter int unsigned DATA_LINE_WIDTH = FLIT_W,
    parameter int unsigned WORD_SIZE       = WORD_W
);
    logic                       i_req_valid;
    logic                       o_req_ready;
    logic [CMD_W-1:0]           i_cmd;
    logic                       i_ext;
    logic [LEN_W-1:0]           i_length;
    logic [WORD_SIZE-1:0]       i_address;
    logic [FEAT_W-1:0]          i_feature1;
    logic [FEAT_W-1:0]          i_feature2;
    logic [WORD_SIZE-1:0]       i_data;
    logic                       i_data_valid;
    logic                       o_data_ready;
    logic                       i_tx_ready;
    logic [DATA_LINE_WIDTH-1:0] o_flit;
    logic                       o_flit_wen;
    logic                       o_err;

    modport slave (
        input  i_req_valid, i_cmd, i_ext, i_length, i_address, i_feature1, i_feature2,
        input  i_data, i_data_valid, i_tx_ready,
        output o_req_ready, o_data_ready, o_flit, o_flit_wen, o_err
    );

    modport master (
        output i_req_valid, i_cmd, i_ext, i_length, i_address, i_feature1, i_feature2,
        output i_data, i_data_valid, i_tx_ready,
        input  o_req_ready, o_data_ready, o_flit, o_flit_wen, o_err
    );
endinterface

// File: rtl/strawman_flit_pack.sv
// Combinational flit assembly from the latched request fields, the current
// state and the live payload word.
module strawman_flit_pack import strawman_pkg::*; #(
    parameter int unsigned DATA_LINE_WIDTH = FLIT_W,
    parameter int unsigned WORD_SIZE       = WORD_W
) (
    input  state_e                     i_state,
    input  req_ctl_t                   i_ctl,
    input  logic [WORD_SIZE-1:0]       i_address,
    input  logic [WORD_SIZE-1:0]       i_data,
    output logic [DATA_LINE_WIDTH-1:0] o_flit_c
);

    always_comb begin
        o_flit_c = '0;
        case (i_state)
            ST_HEADER: begin
                o_flit_c[HDR_EXT_BIT]          = i_ctl.ext;
                o_flit_c[HDR_ONE_BIT]          = 1'b1;
                o_flit_c[HDR_CMD_LSB +: CMD_W] = i_ctl.cmd;
                o_flit_c[HDR_LEN_LSB +: LEN_W] = i_ctl.length;
                // Lightweight read responses piggyback the first data word on the header.
                if (i_ctl.ext) begin
                    o_flit_c[HDR_F1_LSB +: FEAT_W] = i_ctl.feature1;
                    o_flit_c[HDR_F2_LSB +: FEAT_W] = i_ctl.feature2;
                end else if (i_ctl.cmd == CMD_READ_RESP) begin
                    o_flit_c[HDR_PAYLOAD_LSB +: WORD_SIZE] = i_data;
                end else begin
                    o_flit_c[HDR_PAYLOAD_LSB +: WORD_SIZE] = i_address;
                end
            end
            ST_EX_ADDR: o_flit_c[0 +: WORD_SIZE] = i_address;
            ST_BODY:    o_flit_c[0 +: WORD_SIZE] = i_data;
            default:    o_flit_c = '0;
        endcase
    end

endmodule

// File: rtl/strawman_tx_fsm.sv
// Strawman link TX packetiser: accepts one request at a time and emits
// header / extended-address / body flits toward the TX FIFO.
module strawman_tx_fsm import strawman_pkg::*; #(
    parameter int unsigned DATA_LINE_WIDTH = FLIT_W,
    parameter int unsigned WORD_SIZE       = WORD_W
) (
    input logic              clk,
    input logic              rst,
    strawman_tx_fsm_if.slave bus
);

    state_e                     state_q, state_d;
    req_ctl_t                   ctl_q, ctl_d, req_ctl_c;
    logic [WORD_SIZE-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DATA_LINE_WIDTH-1:0] flit_q, flit_d, flit_c;
    logic                       flit_wen_q, flit_wen_d;
    logic                       err_q, err_d;
    logic                       req_ready_c, hs_c, legal_c;
    logic                       data_state_c, emit_c, data_ready_c;

    strawman_flit_pack #(
        .DATA_LINE_WIDTH(DATA_LINE_WIDTH),
        .WORD_SIZE      (WORD_SIZE)
    ) u_flit_pack (
        .i_state  (state_q),
        .i_ctl    (ctl_q),
        .i_address(addr_q),
        .i_data   (bus.i_data),
        .o_flit_c (flit_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hs_c && legal_c) state_d = ST_HEADER;
            ST_HEADER: begin
                if (emit_c) begin
                    if (ctl_q.ext)                                             state_d = ST_EX_ADDR;
                    else if (ctl_q.cmd == CMD_WRITE_REQ)                       state_d = ST_BODY;
                    else if (ctl_q.cmd == CMD_READ_RESP && cnt_q > CNT_W'(1))  state_d = ST_BODY;
                    else                                                       state_d = ST_IDLE;
                end
            end
            ST_EX_ADDR: if (emit_c) state_d = (ctl_q.cmd == CMD_READ_REQ) ? ST_IDLE : ST_BODY;
            ST_BODY:    if (emit_c && cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Handshake, emit qualification and next values for the datapath flops.
    always_comb begin
        req_ctl_c    = '{ext: bus.i_ext, cmd: bus.i_cmd, length: bus.i_length,
                         feature1: bus.i_feature1, feature2: bus.i_feature2};
        req_ready_c  = (state_q == ST_IDLE) && !rst;
        hs_c         = bus.i_req_valid && req_ready_c;
        legal_c      = is_legal(bus.i_cmd, bus.i_length);
        data_state_c = (state_q == ST_BODY) ||
                       (state_q == ST_HEADER && !ctl_q.ext && ctl_q.cmd == CMD_READ_RESP);
        emit_c       = (state_q != ST_IDLE) && bus.i_tx_ready && (!data_state_c || bus.i_data_valid);
        data_ready_c = emit_c && data_state_c && !rst;

        ctl_d  = ctl_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (hs_c) begin
            ctl_d  = req_ctl_c;
            addr_d = bus.i_address;
            cnt_d  = (legal_c && bus.i_cmd != CMD_READ_REQ) ? word_count(bus.i_length) : '0;
        end else if (data_ready_c && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        flit_wen_d = emit_c;
        flit_d     = emit_c ? flit_c : flit_q;
        err_d      = hs_c && !legal_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            flit_q     <= '0;
            flit_wen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ctl_q      <= ctl_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            flit_q     <= flit_d;
            flit_wen_q <= flit_wen_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_req_ready  = req_ready_c;
    assign bus.o_data_ready = data_ready_c;
    assign bus.o_flit       = flit_q;
    assign bus.o_flit_wen   = flit_wen_q;
    assign bus.o_err        = err_q;

endmodule

// File: tb/tb_strawman_tx_fsm.sv
// Self-checking bench for strawman_tx_fsm: table of requests with a flit
// scoreboard, plus hand sequences for latency, stalls, illegal and reset.
module tb_strawman_tx_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strawman_tx_fsm_if bus ();

    strawman_tx_fsm dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic        ext;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [5:0]  f1;
        logic [5:0]  f2;
        logic [31:0] base;
        logic [7:0]  hdr;
        int          n_words;
        bit          err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    int          wen_cyc[$];
    int          flits_seen = 0;
    int          err_seen = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    bit          err_prev = 1'b0;
    logic [39:0] mon_exp;
    vec_t        vecs[11];
    vec_t        v_abort;

    always @(posedge clk) cyc++;

    // Flit monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.o_flit_wen === 1'b1) begin
            flits_seen++;
            wen_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got %010h required none", bus.o_flit);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.o_flit !== mon_exp) begin
                    errors++;
                    $display("FAIL flit: got %010h required %010h", bus.o_flit, mon_exp);
                end
            end
        end
        if (bus.o_err === 1'b1) begin
            err_seen++;
            checks++;
            if (err_prev) begin
                errors++;
                $display("FAIL err_width: got 2+ cycle pulse required 1 cycle");
            end
        end
        err_prev = (bus.o_err === 1'b1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] cmd, input logic ext, input logic [2:0] len,
                                input logic [31:0] addr, input logic [5:0] f1, input logic [5:0] f2,
                                input logic [31:0] base, input logic [7:0] hdr, input int n_words,
                                input bit err);
        vec_t v;
        v.cmd = cmd; v.ext = ext; v.len = len; v.addr = addr; v.f1 = f1; v.f2 = f2;
        v.base = base; v.hdr = hdr; v.n_words = n_words; v.err = err;
        return v;
    endfunction

    task automatic push_expected(input vec_t v);
        int first;
        if (v.err) return;
        if (v.ext)                 exp_q.push_back({20'h0, v.f2, v.f1, v.hdr});
        else if (v.cmd == 3'b010)  exp_q.push_back({v.base, v.hdr});
        else                       exp_q.push_back({v.addr, v.hdr});
        if (v.ext) exp_q.push_back({8'h0, v.addr});
        first = (!v.ext && v.cmd == 3'b010) ? 1 : 0;
        for (int k = first; k < v.n_words; k++) exp_q.push_back({8'h0, v.base + 32'(k)});
    endtask

    // stall_mode: 0 none, 1 random tx/data gaps, 2 tx_ready low for loop cycles 2..4.
    // abort_after >= 0 asserts rst once that many flits of this packet were seen.
    task automatic run_packet(input vec_t v, input int stall_mode, input int abort_after);
        int ptr, iter, err0, start;
        bit done, tx, dv;
        @(negedge clk);
        #1;
        bus.i_req_valid = 1'b1;
        bus.i_cmd       = v.cmd;
        bus.i_ext       = v.ext;
        bus.i_length    = v.len;
        bus.i_address   = v.addr;
        bus.i_feature1  = v.f1;
        bus.i_feature2  = v.f2;
        req_cyc         = cyc;
        #1;
        check("req_ready_idle", 64'(bus.o_req_ready), 64'(1));
        err0  = err_seen;
        start = flits_seen;
        push_expected(v);
        ptr = 0; iter = 0; done = 1'b0;
        while (!done && iter < 400) begin
            @(negedge clk);
            #1;
            bus.i_req_valid = 1'b0;
            if (abort_after >= 0 && flits_seen - start >= abort_after) begin
                rst              = 1'b1;
                bus.i_tx_ready   = 1'b0;
                bus.i_data_valid = 1'b0;
                done             = 1'b1;
            end else begin
                tx = 1'b1;
                dv = (ptr < v.n_words);
                if (stall_mode == 1) begin
                    tx = ($urandom_range(0, 3) != 0);
                    if (dv) dv = ($urandom_range(0, 3) != 0);
                end else if (stall_mode == 2 && iter >= 2 && iter <= 4) begin
                    tx = 1'b0;
                end
                bus.i_tx_ready   = tx;
                bus.i_data_valid = dv;
                bus.i_data       = v.base + 32'(ptr);
                #1;
                checks++;
                if (bus.o_data_ready === 1'b1 && !(tx && dv)) begin
                    errors++;
                    $display("FAIL data_ready_qual: got 1 with tx_ready=%0d data_valid=%0d required 0", tx, dv);
                end
                if (bus.o_data_ready === 1'b1) ptr++;
                if (ptr == v.n_words && bus.o_req_ready === 1'b1) done = 1'b1;
            end
            iter++;
        end
        if (!done) begin
            errors++;
            $display("FAIL packet_timeout: got ptr %0d required %0d words and return to idle", ptr, v.n_words);
        end
        if (abort_after < 0) begin
            bus.i_tx_ready   = 1'b0;
            bus.i_data_valid = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check("sb_drained", 64'(exp_q.size()), 64'(0));
            check("err_pulses", 64'(err_seen - err0), 64'(v.err));
        end
    endtask

    initial begin
        vecs[0]  = mk(3'b001, 1'b0, 3'd1, 32'h12345678, 6'd0,  6'd0,  32'h0000000A, 8'h26, 2,  1'b0);
        vecs[1]  = mk(3'b000, 1'b1, 3'd0, 32'hDEADBEEF, 6'd3,  6'd5,  32'h00000000, 8'h03, 0,  1'b0);
        vecs[2]  = mk(3'b010, 1'b0, 3'd2, 32'h00000000, 6'd0,  6'd0,  32'hC0DE0000, 8'h4A, 4,  1'b0);
        vecs[3]  = mk(3'b001, 1'b1, 3'd2, 32'h0BADF00D, 6'h3F, 6'h2A, 32'h11110000, 8'h47, 4,  1'b0);
        vecs[4]  = mk(3'b010, 1'b1, 3'd1, 32'h55AA55AA, 6'h01, 6'h20, 32'h22220000, 8'h2B, 2,  1'b0);
        vecs[5]  = mk(3'b000, 1'b0, 3'd3, 32'hCAFEF00D, 6'd0,  6'd0,  32'h00000000, 8'h62, 0,  1'b0);
        vecs[6]  = mk(3'b001, 1'b0, 3'd5, 32'h80000004, 6'd0,  6'd0,  32'h33330000, 8'hA6, 32, 1'b0);
        vecs[7]  = mk(3'b010, 1'b0, 3'd0, 32'h00000000, 6'd0,  6'd0,  32'h44440000, 8'h0A, 1,  1'b0);
        vecs[8]  = mk(3'b011, 1'b0, 3'd0, 32'h00000001, 6'd0,  6'd0,  32'h00000000, 8'h00, 0,  1'b1);
        vecs[9]  = mk(3'b001, 1'b0, 3'd6, 32'h00000002, 6'd0,  6'd0,  32'h00000000, 8'h00, 0,  1'b1);
        vecs[10] = mk(3'b111, 1'b1, 3'd2, 32'h00000003, 6'd1,  6'd1,  32'h00000000, 8'h00, 0,  1'b1);
        v_abort  = mk(3'b001, 1'b0, 3'd3, 32'hA5A5A5A5, 6'd0,  6'd0,  32'h55550000, 8'h66, 8,  1'b0);

        rst = 1'b1;
        bus.i_req_valid = 1'b0; bus.i_cmd = '0; bus.i_ext = 1'b0; bus.i_length = '0;
        bus.i_address = '0; bus.i_feature1 = '0; bus.i_feature2 = '0;
        bus.i_data = '0; bus.i_data_valid = 1'b0; bus.i_tx_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_flit_wen",   64'(bus.o_flit_wen),   64'(0));
        check("rst_flit",       64'(bus.o_flit),       64'(0));
        check("rst_err",        64'(bus.o_err),        64'(0));
        check("rst_data_ready", 64'(bus.o_data_ready), 64'(0));
        check("rst_req_ready",  64'(bus.o_req_ready),  64'(0));
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_req_ready", 64'(bus.o_req_ready), 64'(1));

        for (int i = 0; i < 11; i++) run_packet(vecs[i], i % 2, -1);

        // Header latency and back-to-back body flits.
        wen_cyc.delete();
        run_packet(vecs[0], 0, -1);
        check("hdr_flit_count", 64'(wen_cyc.size()), 64'(3));
        if (wen_cyc.size() == 3) begin
            check("hdr_latency",  64'(wen_cyc[0] - req_cyc),    64'(2));
            check("body1_b2b",    64'(wen_cyc[1] - wen_cyc[0]), 64'(1));
            check("body2_b2b",    64'(wen_cyc[2] - wen_cyc[1]), 64'(1));
        end

        // Three-cycle tx_ready stall in the middle of the body.
        run_packet(vecs[0], 2, -1);

        // Illegal command: error pulse only, block back to ready.
        run_packet(vecs[8], 0, -1);
        check("illegal_req_ready", 64'(bus.o_req_ready), 64'(1));

        // Reset after header + two body flits of an 8-word write.
        run_packet(v_abort, 0, 3);
        exp_q.delete();
        @(negedge clk);
        #1;
        check("abort_flit_wen",   64'(bus.o_flit_wen),   64'(0));
        check("abort_req_ready",  64'(bus.o_req_ready),  64'(0));
        check("abort_data_ready", 64'(bus.o_data_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("abort_recover_ready", 64'(bus.o_req_ready), 64'(1));
        check("abort_no_flit",       64'(bus.o_flit_wen),  64'(0));
        run_packet(vecs[0], 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
